mano_prog_loader: RTL and testbench
===================================

MANO_PROG_LOADER -- requirements
Module: mano_prog_loader

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 16, meaning the number of program memory bytes; legal range 2..16.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the flip-flop depth of the input synchronizers.
REQ-003 SHALL have port SysClk  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port load_en  input  1  level; a 0->1 transition requests a load session, and 0 aborts a session.
REQ-006 SHALL have port ser_clk  input  1  external serial bit clock, asynchronous to SysClk.
REQ-007 SHALL have port ser_data  input  1  serial data, MSB first, valid on the ser_clk rising edge.
REQ-008 SHALL have port mem_we  output  1  one-cycle write strobe to the CPU memory.
REQ-009 SHALL have port mem_addr  output  4  write address.
REQ-010 SHALL have port mem_wdata  output  8  write data.
REQ-011 SHALL have port cpu_hold  output  1  high to hold the CPU timing counter at T0 and the PC at 0.
REQ-012 SHALL have port done  output  1  load completed with a good checksum.
REQ-013 SHALL have port err  output  1  load failed.

Function
REQ-014 SHALL pass ser_clk and ser_data through SYNC_STAGES-deep synchronizers, then detect a ser_clk rise as synced value 0 in the previous cycle and 1 in the current cycle.
REQ-015 SHALL, on each detected rise while in LEN, DATA or CSUM, shift the synchronized ser_data into an 8-bit register at the LSB end (first bit ends at bit 7) and increment a 3-bit bit counter.
REQ-016 SHALL treat a byte as complete on the detected rise that carries the 8th bit; the bit counter then wraps to 0.
REQ-017 SHALL implement the states IDLE, LEN, DATA, CSUM, DONE and ERR.
REQ-018 SHALL move IDLE->LEN on a rising edge of load_en; cpu_hold rises in that same cycle.
REQ-019 SHALL, in LEN, load the completed byte as N; N=0 or N>MEM_DEPTH goes to ERR, otherwise the block clears the address counter and sum and goes to DATA.
REQ-020 SHALL, in DATA, for each completed byte assert mem_we for exactly one cycle (the cycle after completion) with mem_addr = address counter and mem_wdata = that byte; it then adds the byte to an 8-bit sum (mod 256) and increments the address.
REQ-021 SHALL go DATA->CSUM when the write count reaches N; the last write address is N-1, and the address never wraps past MEM_DEPTH-1.
REQ-022 SHALL, in CSUM, compare the completed byte with the sum: equal goes to DONE, unequal goes to ERR.
REQ-023 SHALL hold done=1 in DONE and err=1 in ERR, with cpu_hold=0 in both states.
REQ-024 SHALL leave DONE or ERR only for LEN, on a fresh rising edge of load_en; done and err then clear in that same cycle.
REQ-025 SHALL treat load_en=0 in LEN, DATA or CSUM as an abort: next state ERR, partial bit count discarded, no further mem_we.
REQ-026 SHALL ignore ser_clk rises in IDLE, DONE and ERR and SHALL clear the bit counter in those states.
REQ-027 SHALL, if a load_en rise and a byte completion occur in the same cycle, treat the byte as belonging to the new session's LEN state.
REQ-028 SHALL keep mem_we low outside DATA; mem_addr and mem_wdata hold their last values when mem_we=0.

Reset
REQ-029 SHALL, on rst_n=0 and regardless of SysClk, immediately set state IDLE, with mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, done=0, err=0, and the shift register, bit counter, address counter, sum and synchronizers all at 0.
REQ-030 SHALL, on a reset in the middle of a session, leave no pending write, and the first cycle after release SHALL be IDLE.
REQ-031 SHALL require a fresh load_en 0->1 after reset release to start a session; load_en already high at release does not start one.

Verification
REQ-032 Bench SHALL check a good load: N=3, data 0x11,0x22,0x33, checksum 0x66 -> writes (0,0x11),(1,0x22),(2,0x33), each with a one-cycle mem_we, then done=1, err=0, cpu_hold=0.
REQ-033 Bench SHALL check a bad checksum: N=2, data 0xF0,0x20, checksum 0x11 (correct is 0x10) -> two writes, then err=1, done=0.
REQ-034 Bench SHALL check length limits: N=0 -> err=1 with no mem_we; N=17 with MEM_DEPTH=16 -> err=1 with no mem_we; N=16 of 0xFF with checksum 0xF0 -> writes at addresses 0..15, then done=1.
REQ-035 Bench SHALL check an abort: load_en dropped after 4 bits of the second data byte -> exactly one mem_we, then err=1 and cpu_hold=0; a new load_en rise -> LEN with err=0.
REQ-036 Bench SHALL check a mid-session reset: rst_n pulsed low during DATA -> all outputs 0 asynchronously, and no mem_we after release until a new session starts.
REQ-037 Bench SHALL check synchronization: ser_clk toggled with a high/low period of 3 SysClk cycles -> every bit is captured, and a ser_clk high pulse shorter than one SysClk cycle is not required to be captured.

Source files
------------

// File: rtl/mano_prog_loader.sv
// Serial program loader for the Mano CPU memory.
// It receives a length byte, N data bytes and a checksum byte over an
// asynchronous serial link. Each data byte is written to memory, and the CPU
// is held at reset while a load is in progress.
module mano_prog_loader #(
  parameter int MEM_DEPTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       SysClk,
  input  logic       rst_n,
  input  logic       load_en,
  input  logic       ser_clk,
  input  logic       ser_data,
  output logic       mem_we,
  output logic [3:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       cpu_hold,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_q, sdat_q;
  logic       sclk_d;
  logic       load_d;
  logic [7:0] shreg;
  logic [2:0] bitcnt;
  logic [4:0] cnt;
  logic [4:0] nlen;
  logic [7:0] sum;

  logic       clk_s, dat_s;
  logic       ser_rise, load_rise;
  logic       active, byte_done;
  logic [7:0] cur_byte;
  logic       take_len, take_data;

  assign clk_s     = sclk_q[SYNC_STAGES-1];
  assign dat_s     = sdat_q[SYNC_STAGES-1];
  assign ser_rise  = clk_s & ~sclk_d;
  assign load_rise = load_en & ~load_d;
  assign active    = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
  assign byte_done = active && ser_rise && (bitcnt == 3'd7);
  // The byte as it will look once the bit arriving now has been shifted in.
  assign cur_byte  = {shreg[6:0], dat_s};

  assign cpu_hold  = active;
  assign done      = (state == S_DONE);
  assign err       = (state == S_ERR);

  // Synchronizers for serial clock and data. Both have the same depth, so
  // data stays aligned with the clock edge that carries it.
  always_ff @(posedge SysClk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= '0;
      sdat_q <= '0;
      sclk_d <= 1'b0;
    end else begin
      sclk_q[0] <= ser_clk;
      sdat_q[0] <= ser_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_q[i] <= sclk_q[i-1];
        sdat_q[i] <= sdat_q[i-1];
      end
      sclk_d <= clk_s;
    end
  end

  // load_en history. It resets high, so a load_en that is already high when
  // reset is released does not count as a fresh request.
  always_ff @(posedge SysClk or negedge rst_n) begin
    if (!rst_n) load_d <= 1'b1;
    else        load_d <= load_en;
  end

  // State register.
  always_ff @(posedge SysClk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. Inside a session an abort (load_en low) takes priority
  // over a byte that completes in the same cycle.
  always_comb begin
    state_nxt = state;
    take_len  = 1'b0;
    take_data = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (load_rise) state_nxt = S_LEN;
      end
      S_LEN: begin
        if (!load_en) state_nxt = S_ERR;
        else if (byte_done) begin
          if (cur_byte == 8'd0 || cur_byte > 8'(MEM_DEPTH)) begin
            state_nxt = S_ERR;
          end else begin
            take_len  = 1'b1;
            state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (!load_en) state_nxt = S_ERR;
        else if (byte_done) begin
          take_data = 1'b1;
          if ((cnt + 5'd1) == nlen) state_nxt = S_CSUM;
        end
      end
      S_CSUM: begin
        if (!load_en) state_nxt = S_ERR;
        else if (byte_done) state_nxt = (cur_byte == sum) ? S_DONE : S_ERR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bit shifter. The bit count is cleared outside a session and on an abort,
  // so a partial byte is never carried into the next session.
  always_ff @(posedge SysClk or negedge rst_n) begin
    if (!rst_n) begin
      shreg  <= '0;
      bitcnt <= '0;
    end else if (!active || !load_en) begin
      bitcnt <= '0;
    end else if (ser_rise) begin
      shreg  <= cur_byte;
      bitcnt <= bitcnt + 3'd1;
    end
  end

  // Length capture, write strobe, address counter and running checksum.
  // cnt never exceeds N, and N never exceeds MEM_DEPTH, so the address
  // stays in range.
  always_ff @(posedge SysClk or negedge rst_n) begin
    if (!rst_n) begin
      nlen      <= '0;
      cnt       <= '0;
      sum       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= take_data;
      if (take_len) begin
        nlen <= cur_byte[4:0];
        cnt  <= '0;
        sum  <= '0;
      end
      if (take_data) begin
        mem_addr  <= cnt[3:0];
        mem_wdata <= cur_byte;
        sum       <= sum + cur_byte;
        cnt       <= cnt + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_mano_prog_loader.sv
// Bench for mano_prog_loader: directed and random load sessions checked
// against a simple list-based model of the expected memory writes.
module tb_mano_prog_loader;

  logic       SysClk = 1'b0;
  logic       rst_n, load_en, ser_clk, ser_data;
  logic       mem_we, cpu_hold, done, err;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;

  int errors = 0;
  int checks = 0;

  logic [3:0] wq_addr[$];
  logic [7:0] wq_data[$];
  logic [7:0] dbuf[16];
  int hi_g = 3;
  int lo_g = 3;

  mano_prog_loader #(.MEM_DEPTH(16), .SYNC_STAGES(2)) dut (
    .SysClk(SysClk), .rst_n(rst_n), .load_en(load_en), .ser_clk(ser_clk),
    .ser_data(ser_data), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 SysClk = ~SysClk;

  // Record every write strobe; one entry per cycle mem_we is high.
  always @(negedge SysClk) begin
    if (mem_we) begin
      wq_addr.push_back(mem_addr);
      wq_data.push_back(mem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge SysClk);
    ser_data = b;
    repeat (lo_g) @(negedge SysClk);
    ser_clk = 1'b1;
    repeat (hi_g) @(negedge SysClk);
    ser_clk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int nbits = 8);
    for (int i = 7; i > 7 - nbits; i--) send_bit(b[i]);
  endtask

  task automatic clear_q();
    wq_addr.delete();
    wq_data.delete();
  endtask

  task automatic start_session(input string tag);
    @(negedge SysClk);
    load_en = 1'b0;
    repeat (3) @(negedge SysClk);
    load_en = 1'b1;
    repeat (3) @(negedge SysClk);
    chk({tag, ".hold"}, cpu_hold, 1'b1);
    chk({tag, ".busy_done"}, done, 1'b0);
    chk({tag, ".busy_err"}, err, 1'b0);
  endtask

  // Full load of n bytes from dbuf with checksum cs; expectations come from
  // the rules: legal length 1..16, writes (i, dbuf[i]), sum mod 256.
  task automatic run_load(input int n, input logic [7:0] cs, input string tag);
    logic [7:0] s;
    bit legal;
    int exp_nw;
    clear_q();
    start_session(tag);
    legal = (n >= 1) && (n <= 16);
    s = 8'd0;
    send_byte(8'(n));
    if (legal) begin
      for (int i = 0; i < n; i++) begin
        send_byte(dbuf[i]);
        s = s + dbuf[i];
      end
      send_byte(cs);
    end
    repeat (8) @(negedge SysClk);
    exp_nw = legal ? n : 0;
    chk({tag, ".nwr"}, wq_addr.size(), exp_nw);
    for (int i = 0; i < exp_nw && i < wq_addr.size(); i++) begin
      chk($sformatf("%s.addr%0d", tag, i), wq_addr[i], i);
      chk($sformatf("%s.data%0d", tag, i), wq_data[i], dbuf[i]);
    end
    chk({tag, ".done"}, done, legal && (cs == s));
    chk({tag, ".err"}, err, !(legal && (cs == s)));
    chk({tag, ".hold_end"}, cpu_hold, 1'b0);
  endtask

  initial begin
    int n;
    logic [7:0] s;
    rst_n = 1'b0; load_en = 1'b0; ser_clk = 1'b0; ser_data = 1'b0;
    repeat (3) @(negedge SysClk);
    chk("rst.we", mem_we, 0);
    chk("rst.addr", mem_addr, 0);
    chk("rst.wdata", mem_wdata, 0);
    chk("rst.hold", cpu_hold, 0);
    chk("rst.done", done, 0);
    chk("rst.err", err, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge SysClk);

    // Good load, ser_clk high/low 3 cycles each.
    dbuf[0] = 8'h11; dbuf[1] = 8'h22; dbuf[2] = 8'h33;
    run_load(3, 8'h66, "good3");

    // Bad checksum.
    dbuf[0] = 8'hF0; dbuf[1] = 8'h20;
    run_load(2, 8'h11, "badcs");

    // Length limits.
    run_load(0, 8'h00, "len0");
    run_load(17, 8'h00, "len17");
    for (int i = 0; i < 16; i++) dbuf[i] = 8'hFF;
    run_load(16, 8'hF0, "len16");

    // Abort after 4 bits of the second data byte.
    clear_q();
    start_session("abort");
    send_byte(8'd3);
    send_byte(8'hAA);
    send_byte(8'h55, 4);
    @(negedge SysClk);
    load_en = 1'b0;
    repeat (6) @(negedge SysClk);
    chk("abort.nwr", wq_addr.size(), 1);
    if (wq_addr.size() >= 1) begin
      chk("abort.addr", wq_addr[0], 0);
      chk("abort.data", wq_data[0], 8'hAA);
    end
    chk("abort.err", err, 1);
    chk("abort.done", done, 0);
    chk("abort.hold", cpu_hold, 0);
    load_en = 1'b1;
    repeat (3) @(negedge SysClk);
    chk("relen.hold", cpu_hold, 1);
    chk("relen.err", err, 0);
    load_en = 1'b0;
    repeat (3) @(negedge SysClk);

    // Reset in the middle of DATA.
    clear_q();
    start_session("mrst");
    send_byte(8'd4);
    send_byte(8'h5A);
    send_byte(8'hA5);
    send_byte(8'h3C, 4);
    @(negedge SysClk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst.we", mem_we, 0);
    chk("mrst.addr", mem_addr, 0);
    chk("mrst.wdata", mem_wdata, 0);
    chk("mrst.hold", cpu_hold, 0);
    chk("mrst.done", done, 0);
    chk("mrst.err", err, 0);
    repeat (2) @(negedge SysClk);
    rst_n = 1'b1;
    clear_q();
    send_byte(8'h3C, 4);
    send_byte(8'h77);
    send_byte(8'h88);
    repeat (6) @(negedge SysClk);
    chk("mrst.nwr_after", wq_addr.size(), 0);
    chk("mrst.idle_hold", cpu_hold, 0);
    chk("mrst.idle_done", done, 0);
    chk("mrst.idle_err", err, 0);

    // Random sessions with varied serial timing.
    for (int t = 0; t < 6; t++) begin
      hi_g = $urandom_range(3, 5);
      lo_g = $urandom_range(3, 5);
      n = $urandom_range(1, 16);
      s = 8'd0;
      for (int i = 0; i < 16; i++) dbuf[i] = 8'($urandom);
      for (int i = 0; i < n; i++) s = s + dbuf[i];
      if ($urandom_range(0, 1) == 1) s = s ^ 8'(($urandom_range(1, 255)));
      run_load(n, s, $sformatf("rnd%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
